// File: rtl/LDPC_pkg.sv
// Shared LDPC front-end constants: CRC generator polynomials, size limits, CRC-attach FSM states.
package LDPC_pkg;
    localparam logic [23:0] POLY_24A             = 24'h864CFB;
    localparam logic [15:0] POLY_16              = 16'h1021;
    localparam int          MAX_TB_WITH_CRC_SIZE = 8024;
    localparam int          CRC16_THRESH_BITS    = 3824;

    typedef enum logic [1:0] {CRC_IDLE, CRC_DATA, CRC_APPEND, CRC_DRAIN} crc_state_t;
endpackage

// File: rtl/ldpc_crc_byte_update.sv
// Combinational next-CRC for one byte, MSB first, CRC24A or CRC16 (CRC16 lives in the low 16 bits).
module ldpc_crc_byte_update
    import LDPC_pkg::*;
(
    input  logic [23:0] crc_in,
    input  logic [7:0]  byte_in,
    input  logic        sel24,
    output logic [23:0] crc_out
);
    logic [23:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (sel24) begin
                fb = c[23] ^ byte_in[i];
                c  = {c[22:0], 1'b0} ^ (fb ? POLY_24A : 24'h0);
            end else begin
                fb = c[15] ^ byte_in[i];
                c  = {8'h00, c[14:0], 1'b0} ^ (fb ? {8'h00, POLY_16} : 24'h0);
            end
        end
        crc_out = c;
    end
endmodule

// File: rtl/ldpc_tb_crc_attach.sv
// Transport-block CRC attachment: echoes A bits byte-serially, then appends CRC24A or CRC16.
// Optional LDPC_CRC_ERR_INJECT_EN adds err_inject, which flips bit 0 of the final CRC byte.
module ldpc_tb_crc_attach
    import LDPC_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int MAX_TB_BYTES    = 1000,
    parameter int CRC_THRESH_BITS = CRC16_THRESH_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [9:0]        tb_len_bytes,
`ifdef LDPC_CRC_ERR_INJECT_EN
    input  logic              err_inject,
`endif
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_is_crc,
    output logic              busy,
    output logic              len_err
);
    localparam logic [9:0]  MAX_LEN = 10'(MAX_TB_BYTES);
    localparam logic [12:0] THRESH  = 13'(CRC_THRESH_BITS);

    crc_state_t  state;
    logic [9:0]  cnt;
    logic        sel24;
    logic [23:0] crc_reg, crc_next;
    logic [1:0]  crc_idx;
    logic [7:0]  crc_byte;
    logic        len_ok, out_free, inj_q;

    assign len_ok   = (tb_len_bytes != 10'd0) && (tb_len_bytes <= MAX_LEN);
    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == CRC_DATA) && out_free;
    assign busy     = (state != CRC_IDLE);

    ldpc_crc_byte_update u_upd (
        .crc_in  (crc_reg),
        .byte_in (in_data),
        .sel24   (sel24),
        .crc_out (crc_next)
    );

    // crc_idx counts CRC bytes still to emit; CRC16 has zero upper bits so one selector serves both.
    always_comb begin
        case (crc_idx)
            2'd3:    crc_byte = crc_reg[23:16];
            2'd2:    crc_byte = crc_reg[15:8];
            default: crc_byte = crc_reg[7:0];
        endcase
        crc_byte = crc_byte ^ {7'b0, inj_q && (crc_idx == 2'd1)};
    end

`ifdef LDPC_CRC_ERR_INJECT_EN
    always_ff @(posedge clk) begin
        if (rst)
            inj_q <= 1'b0;
        else if (state == CRC_IDLE && start && len_ok)
            inj_q <= err_inject;
    end
`else
    assign inj_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CRC_IDLE;
            cnt        <= '0;
            sel24      <= 1'b0;
            crc_reg    <= '0;
            crc_idx    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_is_crc <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid  <= 1'b0;
                out_last   <= 1'b0;
                out_is_crc <= 1'b0;
            end
            case (state)
                CRC_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            cnt     <= tb_len_bytes;
                            sel24   <= {tb_len_bytes, 3'b000} > THRESH;
                            crc_reg <= '0;
                            state   <= CRC_DATA;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end
                CRC_DATA: begin
                    if (in_valid && in_ready) begin
                        out_data   <= in_data;
                        out_valid  <= 1'b1;
                        out_is_crc <= 1'b0;
                        out_last   <= 1'b0;
                        crc_reg    <= crc_next;
                        cnt        <= cnt - 10'd1;
                        if (cnt == 10'd1) begin
                            crc_idx <= sel24 ? 2'd3 : 2'd2;
                            state   <= CRC_APPEND;
                        end
                    end
                end
                CRC_APPEND: begin
                    if (out_free) begin
                        out_data   <= crc_byte;
                        out_valid  <= 1'b1;
                        out_is_crc <= 1'b1;
                        out_last   <= (crc_idx == 2'd1);
                        crc_idx    <= crc_idx - 2'd1;
                        if (crc_idx == 2'd1)
                            state <= CRC_DRAIN;
                    end
                end
                CRC_DRAIN: begin
                    if (out_valid && out_ready)
                        state <= CRC_IDLE;
                end
                default: state <= CRC_IDLE;
            endcase
        end
    end
endmodule

// File: doc/ldpc_tb_crc_attach.md
Name: ldpc_tb_crc_attach

Overview:
- Upstream neighbour of the LDPC encoder: the transport-block CRC attachment stage defined in TS 38.212 §7.2.1.
- Accepts a byte-serial transport block of A bits and streams it out unchanged.
- Then appends L parity bits: CRC24A (L=24) when A > CRC_THRESH_BITS, otherwise CRC16 (L=16). This produces the B = A+L bit stream consumed by segmentation and encoding.
- Valid/ready streaming on both sides, one registered output stage.

Parameters:
- DATA_W, 8, stream width in bits; only 8 is supported.
- MAX_TB_BYTES, 1000, largest legal A/8 (1000 bytes + 24-bit CRC = MAX_TB_WITH_CRC_SIZE, 8024 bits).
- CRC_THRESH_BITS, 3824, A above this value selects CRC24A, otherwise CRC16.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a TB; sampled only in IDLE
- tb_len_bytes  in  10  A/8, sampled with start
- in_data  in  8  TB byte, MSB = earliest bit (a0 in bit 7)
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  8  output byte, MSB first
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_last  out  1  marks the final CRC byte
- out_is_crc  out  1  out_data is a CRC byte
- busy  out  1  state is not IDLE
- len_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, crc_reg=0, counters=0.
  - in_ready=0, out_valid=0, out_last=0, out_is_crc=0, busy=0, len_err=0, out_data=0.
  - Reset mid-frame discards the partial TB; no CRC is emitted.
- FSM states: IDLE, DATA, CRC, DRAIN.
- IDLE:
  - On start with 1 <= tb_len_bytes <= MAX_TB_BYTES: latch byte count; sel24 = (tb_len_bytes*8 > CRC_THRESH_BITS); crc_reg=0; go to DATA.
  - On start with an illegal length: pulse len_err next cycle, stay in IDLE.
  - start outside IDLE is ignored.
- DATA:
  - in_ready = !out_valid || out_ready.
  - On each in_valid && in_ready: register the byte to the output (out_valid=1, out_is_crc=0), update crc_reg by an 8-bit-parallel MSB-first polynomial division (POLY_24A or POLY_16 from the shared package; init 0, no reflection, no final XOR), and decrement the count.
  - After the last byte is accepted, go to CRC with crc_nbytes = sel24 ? 3 : 2.
- CRC:
  - in_ready=0.
  - Whenever the output register is free or draining, load the next CRC byte, most significant first (p0 in bit 7 of the first CRC byte), with out_is_crc=1.
  - out_last=1 on the final CRC byte. Go to DRAIN once it is loaded.
- DRAIN: when out_valid && out_ready, go to IDLE.
- Output hold rule: out_data, out_valid, out_last and out_is_crc are held stable while out_valid && !out_ready.
- Latency: one cycle from input handshake to out_valid. Full throughput of one byte per cycle when out_ready=1.
- Total output bytes = A/8 + L/8. A one-byte TB is legal.
- Back-to-back frames: start is accepted in the cycle after the DRAIN handshake (one idle cycle minimum).
- busy=1 in DATA, CRC and DRAIN.
- Width rules: crc_reg is 24 bits; CRC16 uses the low 16 bits. Byte count is 10 bits unsigned; the threshold compare is done in 13 bits.

Optional Feature:
- Macro: LDPC_CRC_ERR_INJECT_EN.
- Defined:
  - Adds input port err_inject (1 bit), sampled with an accepted start.
  - If set, bit 0 of the final CRC byte is inverted on output. crc_reg itself is unaffected.
- Undefined: the port is absent and the CRC is always emitted correct.

Decomposition:
- LDPC_pkg holds POLY_24A, POLY_16 and MAX_TB_WITH_CRC_SIZE.
- Add to LDPC_pkg: typedef enum {CRC_IDLE, CRC_DATA, CRC_APPEND, CRC_DRAIN} crc_state_t, and constant CRC16_THRESH_BITS=3824.
- One sub-module: ldpc_crc_byte_update, a combinational next-CRC function with inputs crc_in[23:0], byte, sel24 and output crc_out.

Test Plan:
- CRC16 check value: tb_len=9, ASCII "123456789" -> 9 data bytes echoed, then 0x31, 0xC3; out_last on 0xC3; 11 output beats.
- CRC24A check value: instantiate with CRC_THRESH_BITS=64, same 9 bytes -> trailing 0xCD, 0xE7, 0x03; out_is_crc high for exactly 3 beats.
- Threshold and zeros: tb_len=478 (3824 bits, all zeros) -> CRC16 0x0000 appended (480 beats); tb_len=479 -> CRC24A appended (482 beats).
- Backpressure: out_ready toggled pseudo-randomly, in_valid gapped -> byte stream identical to the ungated run, no duplication or loss, output held stable while stalled.
- Length errors: start with tb_len=0, then tb_len=1001 -> len_err pulses, busy stays 0. rst asserted mid-DATA -> all outputs 0 the next cycle, and the next frame's CRC is correct.
- With LDPC_CRC_ERR_INJECT_EN and err_inject=1, "123456789" in CRC16 mode -> final byte 0xC2.
